// File: rtl/apb_mem_ctrl_pkg.sv
// rtl/apb_mem_ctrl_pkg.sv - shared memory geometry, bus widths and controller state encoding
`timescale 1ns/1ps
package apb_mem_ctrl_pkg;

  localparam int unsigned MEM_WIDTH = 8;
  localparam int unsigned MEM_DEPTH = 4;
  localparam int unsigned MEM_SIZE  = 256;

  localparam int unsigned DATA_W    = MEM_WIDTH * MEM_DEPTH;
  localparam int unsigned STRB_W    = MEM_DEPTH;
  localparam int unsigned MEM_IDX_W = $clog2(MEM_SIZE);

  typedef enum logic [1:0] {
    s_idle = 2'd0,
    s_wait = 2'd1,
    s_mem  = 2'd2,
    s_done = 2'd3
  } apb_ctrl_state_t;

endpackage

// File: rtl/memif.sv
// rtl/memif.sv - word-wide memory bus between the APB controller and apb_mem
`timescale 1ns/1ps
interface memif
  import apb_mem_ctrl_pkg::*;
(
  input logic clk
);

  logic                 mem_rd;
  logic                 mem_wr;
  logic [STRB_W-1:0]    mem_be;
  logic [MEM_IDX_W-1:0] mem_address;
  logic [DATA_W-1:0]    mem_data_in;
  logic [DATA_W-1:0]    mem_data_out;

  modport mem (
    input  clk, mem_rd, mem_wr, mem_be, mem_address, mem_data_in,
    output mem_data_out
  );

  modport ctrl (
    input  clk, mem_data_out,
    output mem_rd, mem_wr, mem_be, mem_address, mem_data_in
  );

endinterface

// File: rtl/apb_mem_ctrl.sv
// rtl/apb_mem_ctrl.sv - APB4 slave turning each transfer into one memif read or write
`timescale 1ns/1ps
module apb_mem_ctrl
  import apb_mem_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned PADDR_WIDTH = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   psel,
  input  logic                   penable,
  input  logic                   pwrite,
  input  logic [PADDR_WIDTH-1:0] paddr,
  input  logic [DATA_W-1:0]      pwdata,
  input  logic [STRB_W-1:0]      pstrb,
  output logic                   pready,
  output logic [DATA_W-1:0]      prdata,
  output logic                   pslverr,
  memif.ctrl                     membus
);

  apb_ctrl_state_t        state;
  logic [3:0]             cnt;
  logic                   wr_q;
  logic                   err_q;
  logic                   setup;
  logic                   addr_err;
  logic [PADDR_WIDTH-3:0] word_idx;

  assign setup    = psel && !penable;
  assign word_idx = paddr[PADDR_WIDTH-1:2];
  assign addr_err = (paddr[1:0] != 2'b00) || (32'(word_idx) >= MEM_SIZE);

  // Strobes drop immediately on a master abort or reset so the memory never commits.
  assign membus.mem_rd = (state == s_mem) && psel && !wr_q && !rst;
  assign membus.mem_wr = (state == s_mem) && psel &&  wr_q && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= s_idle;
      cnt                <= 4'd0;
      wr_q               <= 1'b0;
      err_q              <= 1'b0;
      pready             <= 1'b0;
      pslverr            <= 1'b0;
      prdata             <= '0;
      membus.mem_be      <= '0;
      membus.mem_address <= '0;
      membus.mem_data_in <= '0;
    end else begin
      pready  <= 1'b0;
      pslverr <= 1'b0;
      case (state)
        s_idle: begin
          if (setup) begin
            wr_q               <= pwrite;
            err_q              <= addr_err;
            cnt                <= 4'(WAIT_CYCLES);
            membus.mem_address <= paddr[MEM_IDX_W+1:2];
            membus.mem_data_in <= pwdata;
            membus.mem_be      <= pwrite ? pstrb : '0;
            if (WAIT_CYCLES != 0) begin
              state <= s_wait;
            end else if (addr_err) begin
              state   <= s_done;
              pready  <= 1'b1;
              pslverr <= 1'b1;
            end else begin
              state <= s_mem;
            end
          end
        end
        s_wait: begin
          if (!psel) begin
            state <= s_idle;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
              if (err_q) begin
                state   <= s_done;
                pready  <= 1'b1;
                pslverr <= 1'b1;
              end else begin
                state <= s_mem;
              end
            end
          end
        end
        s_mem: begin
          if (!psel) begin
            state <= s_idle;
          end else begin
            if (!wr_q) prdata <= membus.mem_data_out;
            state  <= s_done;
            pready <= 1'b1;
          end
        end
        s_done: begin
          state <= s_idle;
        end
        default: state <= s_idle;
      endcase
    end
  end

endmodule

// File: doc/apb_mem_ctrl.md
# apb_mem_ctrl

APB slave controller and the initiator side of the `memif` memory bus. It accepts APB4 transfers from the bridge's slave port and turns each one into a single `memif` read or write with byte enables, configurable wait states and error signalling. It sits between the APB fabric and `apb_mem`, and is the only driver of `mem_rd`, `mem_wr`, `mem_be`, `mem_address` and `mem_data_in`.

## Interface
- `WAIT_CYCLES`, default 0: extra wait states inserted before the memory access (0..15).
- `PADDR_WIDTH`, default 12: APB byte-address width; must cover 4*`MEM_SIZE`.
- Data width is fixed at `MEM_WIDTH`*`MEM_DEPTH` (32) bits. Lane count is `MEM_DEPTH` (4). Both come from `apb_arch.svh`.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock; same clock as `membus.clk`.
- `rst`  in  1  synchronous, active-high reset.
- `psel`  in  1  APB select.
- `penable`  in  1  APB enable.
- `pwrite`  in  1  1 = write, 0 = read.
- `paddr`  in  `PADDR_WIDTH`  byte address.
- `pwdata`  in  32  write data.
- `pstrb`  in  4  write byte strobes.
- `pready`  out  1  transfer complete; registered.
- `prdata`  out  32  read data; registered.
- `pslverr`  out  1  error response; registered.
- `membus`  `memif.ctrl` modport  carries `mem_rd`, `mem_wr`, `mem_be[3:0]`, `mem_address`, `mem_data_in[31:0]` (out) and `mem_data_out[31:0]` (in).

## Operation
- FSM states are IDLE, WAIT, MEM and DONE; reset state is IDLE.
- **IDLE**
  - SETUP is `psel`=1 and `penable`=0. On SETUP, latch `pwrite`, `paddr`, `pwdata` and `pstrb`, load the counter with `WAIT_CYCLES`, and compute `err`.
  - Next state: WAIT if `WAIT_CYCLES`>0; otherwise MEM, or DONE if `err`.
- **WAIT**: decrement the counter. When it reaches 0, go to MEM, or to DONE if `err`.
- **MEM**: exactly one cycle, then DONE.
  - Read: `mem_rd`=1. Capture `mem_data_out` into `prdata` at the clock edge.
  - Write: `mem_wr`=1 and `mem_be`=latched `pstrb`. The write commits at this edge.
- **DONE**: `pready`=1 and `pslverr`=`err` for one cycle, then IDLE.
- Address rules:
  - `err` = (`paddr[1:0]`≠0) or (`paddr[PADDR_WIDTH-1:2]` ≥ `MEM_SIZE`).
  - `mem_address` = `paddr[PADDR_WIDTH-1:2]`, truncated to the `MEM_SIZE` index width.
- On an error transfer `mem_rd` and `mem_wr` are never asserted and `prdata` holds its value.
- `prdata` changes only on a successful read; it holds otherwise, including on writes.
- `mem_be` is 0 on reads. A write with `pstrb`=0 still asserts `mem_wr`, updates no byte, and completes OKAY.
- `mem_rd` and `mem_wr` are combinational decodes of state MEM, gated with `psel`. They are never both 1.
- If `psel` drops in WAIT or MEM (master abort), return to IDLE, issue no memory strobe and no `pready`.
- SETUP while not in IDLE is ignored. The master cannot legally do this.

## Timing
- Reset values: `pready`=0, `pslverr`=0, `prdata`=0, `mem_rd`=0, `mem_wr`=0, `mem_be`=0, `mem_address`=0, `mem_data_in`=0, counter=0, state IDLE.
- SETUP in cycle T:
  - Successful transfer: MEM in cycle T+1+`WAIT_CYCLES`, `pready` in cycle T+2+`WAIT_CYCLES`.
  - Error transfer: `pready` in cycle T+1+`WAIT_CYCLES`.
- Minimum ACCESS phase is 2 cycles for OK and 1 cycle for error. `pready` is held 0 until then.
- `mem_address`, `mem_be` and `mem_data_in` are registered at SETUP and stable through MEM.
- Back-to-back transfers: the next SETUP may arrive the cycle after DONE and is accepted from IDLE without a bubble.
- `rst` in any state returns to IDLE at the next edge. No memory strobe is issued in the reset cycle; reset overrides MEM.

## Structure
- State enum typedef `apb_ctrl_state_t` and the data/strobe width constants go into `apb_arch.svh`, next to `MEM_WIDTH`, `MEM_DEPTH` and `MEM_SIZE`.
- Add `modport ctrl` to `memif` as the mirror of `modport mem`.
- Single module, no sub-modules; the wait counter is inline.

## Test plan
- Write 0xDEADBEEF to 0x010 with `pstrb`=4'hF, `WAIT_CYCLES`=0 -> `mem_wr` pulses one cycle with `mem_address`=4 and `mem_be`=4'hF; `pready` one cycle later; `pslverr`=0.
- Read 0x010 after that write -> `mem_rd` one cycle, `prdata`=0xDEADBEEF with `pready`=1 two cycles after SETUP.
- Write 0x11223344 to 0x010 with `pstrb`=4'b0101, then read -> `prdata`=0xDE22BE44.
- `WAIT_CYCLES`=3, read 0x000 -> `pready` exactly 5 cycles after SETUP, `prdata`=0.
- Read 0x012 (misaligned) and write to word `MEM_SIZE` -> `pslverr`=1 with `pready`, no `mem_rd`/`mem_wr`, `prdata` unchanged.
- Assert `rst` during WAIT of a write; separately drop `psel` in WAIT -> no `mem_wr`, no `pready`, FSM back in IDLE and next transfer completes normally.
